// File: rtl/tb_trace_encoder_if.sv
// Bundles the commit, exception-report, trace-record and error signals of the trace encoder.
// The slave modport is the encoder's view; the master modport is the view of whatever drives it.
interface tb_trace_encoder_if #(
    parameter int XLEN = 32
);
    logic            cmt_valid;
    logic [XLEN-1:0] cmt_pc;
    logic [31:0]     cmt_instr;
    logic            cmt_excp;
    logic            excp_valid;
    logic [XLEN-1:0] excp_cause;
    logic [XLEN-1:0] excp_tval;
    logic            trace_ivalid;
    logic [XLEN-1:0] trace_pc;
    logic [31:0]     trace_opcode;
    logic            trace_iexception;
    logic [XLEN-1:0] trace_cause;
    logic [XLEN-1:0] trace_tval;
    logic            err_overflow;
    logic            err_proto;
    logic            err_timeout;

    modport slave (
        input  cmt_valid, cmt_pc, cmt_instr, cmt_excp,
        input  excp_valid, excp_cause, excp_tval,
        output trace_ivalid, trace_pc, trace_opcode, trace_iexception, trace_cause, trace_tval,
        output err_overflow, err_proto, err_timeout
    );

    modport master (
        output cmt_valid, cmt_pc, cmt_instr, cmt_excp,
        output excp_valid, excp_cause, excp_tval,
        input  trace_ivalid, trace_pc, trace_opcode, trace_iexception, trace_cause, trace_tval,
        input  err_overflow, err_proto, err_timeout
    );
endinterface

// File: rtl/tb_trace_encoder.sv
// Pairs in-order commit events with lagging exception reports and emits one trace record per
// commit, flagging overflow, protocol and timeout violations with sticky error bits.
module tb_trace_encoder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    tb_trace_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     opcode;
        logic            excp;
        logic            paired;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } entry_t;

    // Input sampling stage: commits and reports are captured before entering the queue.
    logic            cv_q, cv_d, cexcp_q, cexcp_d, ev_q, ev_d;
    logic [XLEN-1:0] cpc_q, cpc_d, ecause_q, ecause_d, etval_q, etval_d;
    logic [31:0]     cinstr_q, cinstr_d;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pend_idx_q, pend_idx_d;
    logic [AW:0]     count_q, count_d;
    logic            pend_valid_q, pend_valid_d;
    logic [CW-1:0]   tmo_q, tmo_d;

    logic            trace_ivalid_q, trace_ivalid_d, trace_exc_q, trace_exc_d;
    logic [XLEN-1:0] trace_pc_q, trace_pc_d, trace_cause_q, trace_cause_d, trace_tval_q, trace_tval_d;
    logic [31:0]     trace_op_q, trace_op_d;
    logic            err_ovf_q, err_ovf_d, err_proto_q, err_proto_d, err_tmo_q, err_tmo_d;

    logic            full, push, pop;
    entry_t          head, new_entry;

    always_comb begin
        cv_d     = bus.cmt_valid;
        cpc_d    = bus.cmt_pc;
        cinstr_d = bus.cmt_instr;
        cexcp_d  = bus.cmt_excp;
        ev_d     = bus.excp_valid;
        ecause_d = bus.excp_cause;
        etval_d  = bus.excp_tval;

        fifo_d         = fifo_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pend_idx_d     = pend_idx_q;
        pend_valid_d   = pend_valid_q;
        tmo_d          = tmo_q;
        trace_ivalid_d = 1'b0;
        trace_pc_d     = trace_pc_q;
        trace_op_d     = trace_op_q;
        trace_exc_d    = trace_exc_q;
        trace_cause_d  = trace_cause_q;
        trace_tval_d   = trace_tval_q;
        err_ovf_d      = err_ovf_q;
        err_proto_d    = err_proto_q;
        err_tmo_d      = err_tmo_q;

        // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
        full = (count_q == (AW + 1)'(DEPTH));
        push = cv_q && !full;
        head = fifo_q[rd_ptr_q];
        pop  = (count_q != '0) && head.paired;

        if (cv_q && full) err_ovf_d = 1'b1;

        // Resolve the outstanding exception: a report beats a timeout landing in the same cycle.
        if (pend_valid_q) begin
            if (ev_q) begin
                fifo_d[pend_idx_q].cause  = ecause_q;
                fifo_d[pend_idx_q].tval   = etval_q;
                fifo_d[pend_idx_q].paired = 1'b1;
                pend_valid_d              = 1'b0;
            end else if (tmo_q == CW'(TIMEOUT)) begin
                fifo_d[pend_idx_q].cause  = '1;
                fifo_d[pend_idx_q].tval   = '0;
                fifo_d[pend_idx_q].paired = 1'b1;
                pend_valid_d              = 1'b0;
                err_tmo_d                 = 1'b1;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
        end else if (ev_q && !(push && cexcp_q)) begin
            err_proto_d = 1'b1;
        end

        new_entry = '{pc: cpc_q, opcode: cinstr_q, excp: cexcp_q, paired: 1'b1,
                      cause: '0, tval: '0};
        if (cexcp_q) begin
            if (pend_valid_q) begin
                new_entry.cause = '1;
                if (push) err_proto_d = 1'b1;
            end else if (ev_q) begin
                new_entry.cause = ecause_q;
                new_entry.tval  = etval_q;
            end else begin
                new_entry.paired = 1'b0;
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            if (!new_entry.paired) begin
                pend_valid_d = 1'b1;
                pend_idx_d   = wr_ptr_q;
                tmo_d        = '0;
            end
        end

        if (pop) begin
            rd_ptr_d       = rd_ptr_q + AW'(1);
            trace_ivalid_d = 1'b1;
            trace_pc_d     = head.pc;
            trace_op_d     = head.opcode;
            trace_exc_d    = head.excp;
            trace_cause_d  = head.cause;
            trace_tval_d   = head.tval;
        end

        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q <= 1'b0; cpc_q <= '0; cinstr_q <= '0; cexcp_q <= 1'b0;
            ev_q <= 1'b0; ecause_q <= '0; etval_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0; rd_ptr_q <= '0; pend_idx_q <= '0; count_q <= '0;
            pend_valid_q <= 1'b0; tmo_q <= '0;
            trace_ivalid_q <= 1'b0; trace_pc_q <= '0; trace_op_q <= '0; trace_exc_q <= 1'b0;
            trace_cause_q <= '0; trace_tval_q <= '0;
            err_ovf_q <= 1'b0; err_proto_q <= 1'b0; err_tmo_q <= 1'b0;
        end else begin
            cv_q <= cv_d; cpc_q <= cpc_d; cinstr_q <= cinstr_d; cexcp_q <= cexcp_d;
            ev_q <= ev_d; ecause_q <= ecause_d; etval_q <= etval_d;
            fifo_q <= fifo_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; pend_idx_q <= pend_idx_d; count_q <= count_d;
            pend_valid_q <= pend_valid_d; tmo_q <= tmo_d;
            trace_ivalid_q <= trace_ivalid_d; trace_pc_q <= trace_pc_d; trace_op_q <= trace_op_d;
            trace_exc_q <= trace_exc_d; trace_cause_q <= trace_cause_d; trace_tval_q <= trace_tval_d;
            err_ovf_q <= err_ovf_d; err_proto_q <= err_proto_d; err_tmo_q <= err_tmo_d;
        end
    end

    assign bus.trace_ivalid     = trace_ivalid_q;
    assign bus.trace_pc         = trace_pc_q;
    assign bus.trace_opcode     = trace_op_q;
    assign bus.trace_iexception = trace_exc_q;
    assign bus.trace_cause      = trace_cause_q;
    assign bus.trace_tval       = trace_tval_q;
    assign bus.err_overflow     = err_ovf_q;
    assign bus.err_proto        = err_proto_q;
    assign bus.err_timeout      = err_tmo_q;
endmodule

// File: tb/tb_tb_trace_encoder.sv
// Scoreboard bench for tb_trace_encoder: directed commits push expected records, a monitor
// pops and compares each emitted trace record; flags, latency and reset are checked directly.
module tb_tb_trace_encoder;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op;
        logic        exc;
        logic [31:0] cause;
        logic [31:0] tval;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tb_trace_encoder_if #(.XLEN(XLEN)) bus ();

    tb_trace_encoder #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rec_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rec_t mon_act, mon_exp;
    int   c0, d;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ex, input logic ev, input logic [31:0] cause,
                         input logic [31:0] tval);
        @(negedge clk);
        bus.cmt_valid  = cv;
        bus.cmt_pc     = pc;
        bus.cmt_instr  = instr;
        bus.cmt_excp   = ex;
        bus.excp_valid = ev;
        bus.excp_cause = cause;
        bus.excp_tval  = tval;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expect_rec(input logic [31:0] pc, input logic [31:0] op, input logic exc,
                              input logic [31:0] cause, input logic [31:0] tval);
        sb.push_back(rec_t'{pc, op, exc, cause, tval});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, 160'(sb.size()), 160'(0));
    endtask

    function automatic logic [159:0] all_outputs();
        return 160'({bus.trace_ivalid, bus.trace_pc, bus.trace_opcode, bus.trace_iexception,
                     bus.trace_cause, bus.trace_tval, bus.err_overflow, bus.err_proto,
                     bus.err_timeout});
    endfunction

    function automatic logic [159:0] err_flags();
        return 160'({bus.err_overflow, bus.err_proto, bus.err_timeout});
    endfunction

    initial begin
        bus.cmt_valid = 1'b0; bus.cmt_pc = '0; bus.cmt_instr = '0; bus.cmt_excp = 1'b0;
        bus.excp_valid = 1'b0; bus.excp_cause = '0; bus.excp_tval = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus.trace_ivalid === 1'b1) begin
                    mon_act = {bus.trace_pc, bus.trace_opcode, bus.trace_iexception,
                               bus.trace_cause, bus.trace_tval};
                    pop_cyc.push_back(cyc);
                    $display("record cyc=%0d pc=%h op=%h exc=%0b cause=%h tval=%h", cyc,
                             mon_act.pc, mon_act.op, mon_act.exc, mon_act.cause, mon_act.tval);
                    if (sb.size() == 0) begin
                        check("unexpected_record", 160'(mon_act), 160'(0));
                    end else begin
                        mon_exp = sb.pop_front();
                        check("record", 160'(mon_act), 160'(mon_exp));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_state", all_outputs(), 160'(0));
        rst_n = 1'b1;

        // Four back-to-back plain commits
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i == 0) c0 = cyc;
            expect_rec(32'h80000000 + 32'(4 * i), 32'h00000013, 1'b0, 32'h0, 32'h0);
        end
        idle();
        wait_drain("t1_drain");
        check("t1_count", 160'(pop_cyc.size()), 160'(4));
        if (pop_cyc.size() == 4) begin
            check("t1_latency", 160'(pop_cyc[0] - c0), 160'(3));
            check("t1_no_bubbles", 160'(pop_cyc[3] - pop_cyc[0]), 160'(3));
        end
        check("t1_hold_pc", 160'(bus.trace_pc), 160'(32'h8000000C));
        check("t1_flags", err_flags(), 160'(0));

        // Exception with report lagging 3 cycles, two plain commits queued behind it
        pop_cyc.delete();
        drive(1'b1, 32'h80000010, 32'h00000073, 1'b1, 1'b0, 32'h0, 32'h0);
        expect_rec(32'h80000010, 32'h00000073, 1'b1, 32'hB, 32'h0);
        drive(1'b1, 32'h80000014, 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_rec(32'h80000014, 32'h00000013, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h80000018, 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_rec(32'h80000018, 32'h00000013, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB, 32'h0);
        idle();
        wait_drain("t2_drain");
        check("t2_count", 160'(pop_cyc.size()), 160'(3));
        if (pop_cyc.size() == 3) check("t2_consecutive", 160'(pop_cyc[2] - pop_cyc[0]), 160'(2));
        check("t2_flags", err_flags(), 160'(0));

        // Zero-lag report
        pop_cyc.delete();
        drive(1'b1, 32'h80000020, 32'h00100073, 1'b1, 1'b1, 32'h2, 32'hDEADBEEF);
        c0 = cyc;
        expect_rec(32'h80000020, 32'h00100073, 1'b1, 32'h2, 32'hDEADBEEF);
        idle();
        wait_drain("t3_drain");
        if (pop_cyc.size() == 1) check("t3_latency", 160'(pop_cyc[0] - c0), 160'(3));
        else check("t3_count", 160'(pop_cyc.size()), 160'(1));
        check("t3_flags", err_flags(), 160'(0));

        // Pending head plus DEPTH further commits: the last one is dropped
        pop_cyc.delete();
        drive(1'b1, 32'h80000030, 32'h00000073, 1'b1, 1'b0, 32'h0, 32'h0);
        expect_rec(32'h80000030, 32'h00000073, 1'b1, 32'h5, 32'h1234);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 32'h80000030 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i < DEPTH) expect_rec(32'h80000030 + 32'(4 * i), 32'h00000013, 1'b0, 32'h0, 32'h0);
        end
        repeat (3) idle();
        check("t4_overflow_flag", 160'(bus.err_overflow), 160'(1));
        check("t4_blocked", 160'(pop_cyc.size()), 160'(0));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5, 32'h1234);
        idle();
        wait_drain("t4_drain");
        check("t4_count", 160'(pop_cyc.size()), 160'(DEPTH));
        check("t4_other_flags", 160'({bus.err_proto, bus.err_timeout}), 160'(0));

        // Exception with no report: forced release after TIMEOUT, then a late report
        pop_cyc.delete();
        drive(1'b1, 32'h80000050, 32'h00000073, 1'b1, 1'b0, 32'h0, 32'h0);
        c0 = cyc;
        expect_rec(32'h80000050, 32'h00000073, 1'b1, 32'hFFFFFFFF, 32'h0);
        idle();
        repeat (TIMEOUT - 6) @(negedge clk);
        check("t5_no_early_timeout", 160'(bus.err_timeout), 160'(0));
        for (int i = 0; i < 100 && pop_cyc.size() == 0; i++) @(negedge clk);
        if (pop_cyc.size() == 0) begin
            check("t5_release_seen", 160'(0), 160'(1));
        end else begin
            d = pop_cyc[0] - c0;
            check("t5_release_window", 160'(d >= TIMEOUT + 2 && d <= TIMEOUT + 5), 160'(1));
        end
        check("t5_timeout_flag", 160'(bus.err_timeout), 160'(1));
        check("t5_proto_before", 160'(bus.err_proto), 160'(0));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7, 32'h0);
        idle();
        repeat (3) @(negedge clk);
        check("t5_proto_after", 160'(bus.err_proto), 160'(1));
        wait_drain("t5_drain");

        // Mid-operation reset with entries queued behind a pending exception
        drive(1'b1, 32'h80000060, 32'h00000073, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h80000064, 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h80000068, 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", all_outputs(), 160'(0));
        @(negedge clk);
        check("t6_reset_hold", all_outputs(), 160'(0));
        rst_n = 1'b1;
        pop_cyc.delete();
        drive(1'b1, 32'h80000100, 32'h00000013, 1'b0, 1'b0, 32'h0, 32'h0);
        c0 = cyc;
        expect_rec(32'h80000100, 32'h00000013, 1'b0, 32'h0, 32'h0);
        idle();
        wait_drain("t6_drain");
        if (pop_cyc.size() == 1) check("t6_latency", 160'(pop_cyc[0] - c0), 160'(3));
        else check("t6_count", 160'(pop_cyc.size()), 160'(1));
        check("t6_flags", err_flags(), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
